// File: rtl/out_port_fifo_if.sv
// out_port_fifo_if: CPU-write / device-drain signal bundle for out_port_fifo.
// slave  = the FIFO's view, master = the view of whoever drives strobes and drains.
interface out_port_fifo_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CHANNELS = 1
);
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned CW   = $clog2(DEPTH) + 1;

  logic             OutPortIn;
  logic [WIDTH-1:0] BusMuxOut;
  logic [CH_W-1:0]  chan;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CH_W-1:0]  out_chan;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             chan_err;
  logic             err_clr;

  modport slave (
    input  OutPortIn, BusMuxOut, chan, out_ready, err_clr,
    output out_valid, out_data, out_chan, full, empty, count, overflow, chan_err
  );

  modport master (
    output OutPortIn, BusMuxOut, chan, out_ready, err_clr,
    input  out_valid, out_data, out_chan, full, empty, count, overflow, chan_err
  );
endinterface

// File: rtl/out_port_fifo.sv
// out_port_fifo: edge-triggered CPU output port feeding a channel-tagged FWFT FIFO
// drained over valid/ready. Optional OUTPORT_LEGACY_EN adds legacy_q, the last
// accepted channel-0 word (old single-register outport behaviour).
module out_port_fifo #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CHANNELS = 1
) (
  input  logic             clk,
  input  logic             clr,
`ifdef OUTPORT_LEGACY_EN
  output logic [WIDTH-1:0] legacy_q,
`endif
  out_port_fifo_if.slave   bus
);
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam logic [CW-1:0]   DepthCnt = DEPTH[CW-1:0];
  localparam logic [CH_W:0]   ChanLim  = CHANNELS[CH_W:0];

  logic             r_ip;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_mem_data [DEPTH];
  logic [CH_W-1:0]  r_mem_chan [DEPTH];
  logic             r_ovf;
  logic             r_cerr;

  logic w_push_req, w_chan_ok, w_full, w_empty, w_pop, w_push;
  logic w_ovf_set, w_cerr_set;

  assign w_push_req = bus.OutPortIn & ~r_ip;
  assign w_chan_ok  = {1'b0, bus.chan} < ChanLim;
  assign w_full     = (r_count == DepthCnt);
  assign w_empty    = (r_count == '0);
  assign w_pop      = ~w_empty & bus.out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push     = w_push_req & w_chan_ok & (~w_full | w_pop);
  // Channel check wins: a bad channel on a full FIFO is not an overflow.
  assign w_ovf_set  = w_push_req & w_chan_ok & w_full & ~w_pop;
  assign w_cerr_set = w_push_req & ~w_chan_ok;

  // Strobe edge detector, pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_ip     <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_cerr   <= 1'b0;
    end else begin
      r_ip <= bus.OutPortIn;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Set beats clear when both happen in one cycle.
      r_ovf  <= w_ovf_set  | (r_ovf  & ~bus.err_clr);
      r_cerr <= w_cerr_set | (r_cerr & ~bus.err_clr);
    end
  end

  // Entry storage; cleared on reset so the head reads zero until first write.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_chan[i] <= '0;
      end
    end else if (w_push) begin
      r_mem_data[r_wr_ptr] <= bus.BusMuxOut;
      r_mem_chan[r_wr_ptr] <= bus.chan;
    end
  end

`ifdef OUTPORT_LEGACY_EN
  logic [WIDTH-1:0] r_legacy;

  // Mirror of the last accepted channel-0 word, independent of pops.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_legacy <= '0;
    end else if (w_push && (bus.chan == '0)) begin
      r_legacy <= bus.BusMuxOut;
    end
  end

  assign legacy_q = r_legacy;
`endif

  assign bus.out_valid = ~w_empty;
  assign bus.out_data  = r_mem_data[r_rd_ptr];
  assign bus.out_chan  = r_mem_chan[r_rd_ptr];
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.count     = r_count;
  assign bus.overflow  = r_ovf;
  assign bus.chan_err  = r_cerr;
endmodule

// File: tb/tb_out_port_fifo.sv
// tb_out_port_fifo: directed, table-driven bench for out_port_fifo
// (WIDTH=32, DEPTH=4, CHANNELS=3 so that chan=3 is out of range).
module tb_out_port_fifo;
  logic clk = 1'b0;
  logic clr = 1'b0;

  out_port_fifo_if #(.WIDTH(32), .DEPTH(4), .CHANNELS(3)) bus_if ();

`ifdef OUTPORT_LEGACY_EN
  logic [31:0] legacy_q;
  out_port_fifo #(.WIDTH(32), .DEPTH(4), .CHANNELS(3)) dut (
    .clk      (clk),
    .clr      (clr),
    .legacy_q (legacy_q),
    .bus      (bus_if)
  );
`else
  out_port_fifo #(.WIDTH(32), .DEPTH(4), .CHANNELS(3)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if)
  );
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic        s;     // OutPortIn
    logic [31:0] d;     // BusMuxOut
    logic [1:0]  c;     // chan
    logic        r;     // out_ready
    logic        ec;    // err_clr
    logic        ev;    // expected out_valid
    logic [31:0] ed;    // expected out_data (checked only when valid)
    logic [1:0]  ech;   // expected out_chan (checked only when valid)
    logic [2:0]  ecnt;  // expected count
    logic        eo;    // expected overflow
    logic        ece;   // expected chan_err
    logic [31:0] el;    // expected legacy_q
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic s, input logic [31:0] d, input logic [1:0] c,
                              input logic r, input logic ec, input logic ev,
                              input logic [31:0] ed, input logic [1:0] ech,
                              input logic [2:0] ecnt, input logic eo, input logic ece,
                              input logic [31:0] el);
    vec_t v;
    v.s = s; v.d = d; v.c = c; v.r = r; v.ec = ec; v.ev = ev; v.ed = ed; v.ech = ech;
    v.ecnt = ecnt; v.eo = eo; v.ece = ece; v.el = el;
    return v;
  endfunction

  // Compare full observable state; head data/chan masked while empty.
  task automatic check(input string name, input logic ev, input logic [31:0] ed,
                       input logic [1:0] ech, input logic [2:0] ecnt, input logic eo,
                       input logic ece, input logic [31:0] el);
    logic [41:0] act, exp;
    logic        efull, eempty;
    efull  = (ecnt == 3'd4);
    eempty = (ecnt == 3'd0);
    exp = {ev, efull, eempty, eo, ece, ecnt, ech, ed};
    act = {bus_if.out_valid, bus_if.full, bus_if.empty, bus_if.overflow, bus_if.chan_err,
           bus_if.count, (ev ? bus_if.out_chan : ech), (ev ? bus_if.out_data : ed)};
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got v=%b f=%b e=%b ovf=%b cerr=%b cnt=%0d ch=%0d d=%h, want v=%b f=%b e=%b ovf=%b cerr=%b cnt=%0d ch=%0d d=%h",
               name, act[41], act[40], act[39], act[38], act[37], act[36:34], act[33:32],
               act[31:0], exp[41], exp[40], exp[39], exp[38], exp[37], exp[36:34],
               exp[33:32], exp[31:0]);
    end
`ifdef OUTPORT_LEGACY_EN
    n_vec++;
    if (legacy_q !== el) begin
      n_fail++;
      $display("FAIL %s legacy_q: got %h want %h", name, legacy_q, el);
    end
`else
    if (el === 32'hx) $display("unreachable");
`endif
  endtask

  task automatic drive(input logic s, input logic [31:0] d, input logic [1:0] c,
                       input logic r, input logic ec);
    bus_if.OutPortIn = s;
    bus_if.BusMuxOut = d;
    bus_if.chan      = c;
    bus_if.out_ready = r;
    bus_if.err_clr   = ec;
  endtask

  initial begin
    // 0x0A single out (strobe held 4 clocks, held across reset release), then pop.
    vecs.push_back(mk(1, 32'h0A, 0, 0, 0, 1, 32'h0A, 0, 1, 0, 0, 32'h0A));
    vecs.push_back(mk(1, 32'h0A, 0, 0, 0, 1, 32'h0A, 0, 1, 0, 0, 32'h0A));
    vecs.push_back(mk(1, 32'h0A, 0, 0, 0, 1, 32'h0A, 0, 1, 0, 0, 32'h0A));
    vecs.push_back(mk(1, 32'h0A, 0, 0, 0, 1, 32'h0A, 0, 1, 0, 0, 32'h0A));
    vecs.push_back(mk(0, 32'h00, 0, 0, 0, 1, 32'h0A, 0, 1, 0, 0, 32'h0A));
    vecs.push_back(mk(0, 32'h00, 0, 1, 0, 0, 32'h00, 0, 0, 0, 0, 32'h0A));
    // Fill 1..4, 5 overflows.
    vecs.push_back(mk(1, 32'h01, 0, 0, 0, 1, 32'h01, 0, 1, 0, 0, 32'h01));
    vecs.push_back(mk(0, 32'h00, 0, 0, 0, 1, 32'h01, 0, 1, 0, 0, 32'h01));
    vecs.push_back(mk(1, 32'h02, 0, 0, 0, 1, 32'h01, 0, 2, 0, 0, 32'h02));
    vecs.push_back(mk(0, 32'h00, 0, 0, 0, 1, 32'h01, 0, 2, 0, 0, 32'h02));
    vecs.push_back(mk(1, 32'h03, 0, 0, 0, 1, 32'h01, 0, 3, 0, 0, 32'h03));
    vecs.push_back(mk(0, 32'h00, 0, 0, 0, 1, 32'h01, 0, 3, 0, 0, 32'h03));
    vecs.push_back(mk(1, 32'h04, 0, 0, 0, 1, 32'h01, 0, 4, 0, 0, 32'h04));
    vecs.push_back(mk(0, 32'h00, 0, 0, 0, 1, 32'h01, 0, 4, 0, 0, 32'h04));
    vecs.push_back(mk(1, 32'h05, 0, 0, 0, 1, 32'h01, 0, 4, 1, 0, 32'h04));
    vecs.push_back(mk(0, 32'h00, 0, 0, 0, 1, 32'h01, 0, 4, 1, 0, 32'h04));
    vecs.push_back(mk(0, 32'h00, 0, 0, 1, 1, 32'h01, 0, 4, 0, 0, 32'h04));
    // Push 9 with a pop while full: count stays 4, no overflow.
    vecs.push_back(mk(1, 32'h09, 0, 1, 0, 1, 32'h02, 0, 4, 0, 0, 32'h09));
    vecs.push_back(mk(0, 32'h00, 0, 0, 0, 1, 32'h02, 0, 4, 0, 0, 32'h09));
    vecs.push_back(mk(0, 32'h00, 0, 1, 0, 1, 32'h03, 0, 3, 0, 0, 32'h09));
    vecs.push_back(mk(0, 32'h00, 0, 1, 0, 1, 32'h04, 0, 2, 0, 0, 32'h09));
    vecs.push_back(mk(0, 32'h00, 0, 1, 0, 1, 32'h09, 0, 1, 0, 0, 32'h09));
    vecs.push_back(mk(0, 32'h00, 0, 1, 0, 0, 32'h00, 0, 0, 0, 0, 32'h09));
    // Channel errors and sticky clear (set wins over clear).
    vecs.push_back(mk(1, 32'h55, 3, 0, 0, 0, 32'h00, 0, 0, 0, 1, 32'h09));
    vecs.push_back(mk(0, 32'h00, 0, 0, 1, 0, 32'h00, 0, 0, 0, 0, 32'h09));
    vecs.push_back(mk(1, 32'h55, 3, 0, 1, 0, 32'h00, 0, 0, 0, 1, 32'h09));
    vecs.push_back(mk(0, 32'h00, 0, 0, 1, 0, 32'h00, 0, 0, 0, 0, 32'h09));
    // Tagged entries, fill, bad channel on full sets only chan_err.
    vecs.push_back(mk(1, 32'h77, 2, 0, 0, 1, 32'h77, 2, 1, 0, 0, 32'h09));
    vecs.push_back(mk(0, 32'h00, 0, 0, 0, 1, 32'h77, 2, 1, 0, 0, 32'h09));
    vecs.push_back(mk(1, 32'h78, 1, 0, 0, 1, 32'h77, 2, 2, 0, 0, 32'h09));
    vecs.push_back(mk(0, 32'h00, 0, 0, 0, 1, 32'h77, 2, 2, 0, 0, 32'h09));
    vecs.push_back(mk(1, 32'h79, 0, 0, 0, 1, 32'h77, 2, 3, 0, 0, 32'h79));
    vecs.push_back(mk(0, 32'h00, 0, 0, 0, 1, 32'h77, 2, 3, 0, 0, 32'h79));
    vecs.push_back(mk(1, 32'h7A, 0, 0, 0, 1, 32'h77, 2, 4, 0, 0, 32'h7A));
    vecs.push_back(mk(0, 32'h00, 0, 0, 0, 1, 32'h77, 2, 4, 0, 0, 32'h7A));
    vecs.push_back(mk(1, 32'hEE, 3, 0, 0, 1, 32'h77, 2, 4, 0, 1, 32'h7A));
    vecs.push_back(mk(0, 32'h00, 0, 0, 1, 1, 32'h77, 2, 4, 0, 0, 32'h7A));
    vecs.push_back(mk(0, 32'h00, 0, 1, 0, 1, 32'h78, 1, 3, 0, 0, 32'h7A));
    vecs.push_back(mk(0, 32'h00, 0, 1, 0, 1, 32'h79, 0, 2, 0, 0, 32'h7A));
    vecs.push_back(mk(0, 32'h00, 0, 1, 0, 1, 32'h7A, 0, 1, 0, 0, 32'h7A));
    vecs.push_back(mk(0, 32'h00, 0, 1, 0, 0, 32'h00, 0, 0, 0, 0, 32'h7A));
    // Ready while empty must not underflow.
    vecs.push_back(mk(0, 32'h00, 0, 1, 0, 0, 32'h00, 0, 0, 0, 0, 32'h7A));

    // Reset with strobe held high.
    drive(1, 32'h0A, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (bus_if.out_data !== 32'h0 || bus_if.out_chan !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_head: got d=%h ch=%0d want d=0 ch=0",
               bus_if.out_data, bus_if.out_chan);
    end
    check("reset", 0, 32'h0, 0, 0, 0, 0, 32'h0);

    // Release on a falling edge with strobe still high: first edge is a write.
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].s, vecs[i].d, vecs[i].c, vecs[i].r, vecs[i].ec);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ech, vecs[i].ecnt,
            vecs[i].eo, vecs[i].ece, vecs[i].el);
    end

    // Wrap-around: 10 push/pop pairs.
    for (int i = 0; i < 10; i++) begin
      logic [31:0] ld;
      ld = 32'h7A;
      for (int j = 0; j <= i; j++) if (j % 3 == 0) ld = 32'h100 + j;
      drive(1, 32'h100 + i, 2'(i % 3), 0, 0);
      @(posedge clk);
      #1;
      check($sformatf("wrap_push%0d", i), 1, 32'h100 + i, 2'(i % 3), 1, 0, 0, ld);
      drive(0, 32'h0, 0, 1, 0);
      @(posedge clk);
      #1;
      check($sformatf("wrap_pop%0d", i), 0, 32'h0, 0, 0, 0, 0, ld);
    end

    // Two queued entries, then asynchronous reset between edges.
    drive(1, 32'hAA, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 32'h0, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(1, 32'hBB, 0, 0, 0);
    @(posedge clk);
    #1;
    check("two_queued", 1, 32'hAA, 0, 2, 0, 0, 32'hBB);
    drive(0, 32'h0, 0, 1, 0);
    #2;
    clr = 1'b0;
    #1;
    check("async_reset", 0, 32'h0, 0, 0, 0, 0, 32'h0);
    n_vec++;
    if (bus_if.out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset_data: got %h want 0", bus_if.out_data);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
